// File: rtl/spectro_pkg.sv
// Shared definitions for the spectrogram readout path: sequencer state
// encoding and the per-slot length helper.
// Optional build macro FRAME_PARITY_EN appends an even-parity bit to every slot.
package spectro_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SEND  = ST_SEND,
        CLEAR = ST_CLEAR
    } state_e;

    // Serial cycles spent on one slot: the word itself plus the optional parity bit.
    function automatic int slot_len(input int word_w);
`ifdef FRAME_PARITY_EN
        return word_w + 1;
`else
        return word_w;
`endif
    endfunction

endpackage

// File: rtl/frame_serializer_piso.sv
// piso_shift: parallel-in serial-out register with a registered serial tap.
// q carries the bit chosen during the previous cycle: the word MSB on load,
// the next lower bit on each shift, the captured parity when emit_par is set,
// and 0 otherwise.
// Optional build macro FRAME_PARITY_EN adds the parity capture register.
module piso_shift #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         emit_par,
    input  logic [W-1:0] d,
    output logic         q
);

    logic [W-1:0] shreg;
    logic         par_bit;

`ifdef FRAME_PARITY_EN
    // Even parity of the word, captured alongside the load so it outlives the shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (load) begin
            par_bit <= ^d;
        end
    end
`else
    assign par_bit = 1'b0;
`endif

    // Word register: load the whole word, then move it up one place per shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (shift) begin
            shreg <= {shreg[W-2:0], 1'b0};
        end
    end

    // Serial output: after every load/shift q equals the new shreg MSB, so the
    // shift path taps the bit that is about to move into the MSB position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else if (load) begin
            q <= d[W-1];
        end else if (shift) begin
            q <= shreg[W-2];
        end else if (emit_par) begin
            q <= par_bit;
        end else begin
            q <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: on an ovf request walks N_SLOTS slots (slot 0 = RTC,
// the rest channel counters), steering the external mux with sel, loading each
// word into the PISO and shifting it out MSB first, then pulses rst_ch once.
// Optional build macro FRAME_PARITY_EN: each slot gets a trailing even-parity bit.
module frame_serializer
    import spectro_pkg::*;
#(
    parameter int N_SLOTS = 16,
    parameter int WORD_W  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ovf,
    input  logic [WORD_W-1:0]          data_in,
    output logic [$clog2(N_SLOTS)-1:0] sel,
    output logic                       load,
    output logic                       ser_out,
    output logic                       ser_valid,
    output logic                       busy,
    output logic                       rst_ch,
    output logic                       overrun
);

    localparam int SEL_W    = $clog2(N_SLOTS);
    localparam int SLOT_LEN = slot_len(WORD_W);
    localparam int CNT_W    = $clog2(SLOT_LEN);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SLOT_LEN - 1);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_SLOTS - 1);

    state_e           state;
    logic [SEL_W-1:0] slot;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_q;
    logic             in_send;
    logic             par_cycle;
    logic             shift;

    assign in_send = (state == SEND);
`ifdef FRAME_PARITY_EN
    // The extra bit after the word LSB is the parity slot.
    assign par_cycle = in_send && (bit_cnt == LAST_BIT);
`else
    assign par_cycle = 1'b0;
`endif

    assign sel    = slot;
    assign load   = in_send && (bit_cnt == '0);
    assign shift  = in_send && !load && !par_cycle;
    assign busy   = (state != IDLE);
    assign rst_ch = (state == CLEAR);

    // Sequencer: slot and bit counters advance only while sending a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            slot    <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ovf) begin
                        state   <= SEND;
                        slot    <= '0;
                        bit_cnt <= '0;
                    end
                end
                SEND: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (slot == LAST_SLOT) begin
                            state <= CLEAR;
                            slot  <= '0;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Valid qualifier: registered with the same one-cycle lag as ser_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_valid <= 1'b0;
        end else begin
            ser_valid <= in_send;
        end
    end

    // Overrun: a fresh request (ovf rising) arriving while a frame is in flight.
    // A level held from IDLE through the frame is a back-to-back request, not an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            ovf_q <= ovf;
            if (busy && ovf && !ovf_q) begin
                overrun <= 1'b1;
            end
        end
    end

    piso_shift #(
        .W (WORD_W)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .emit_par (par_cycle),
        .d        (data_in),
        .q        (ser_out)
    );

endmodule
